// File: rtl/loud_box_pkg.sv
// Shared types and constants for the emitter scheduler: slot states and the
// entropy LFSR definition.
package loud_box_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } slot_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Galois step with one bit of external noise folded into bit 0; the
    // all-zero lock-up state is replaced by the seed.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur, input logic din);
        logic [15:0] nxt;
        nxt    = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
        nxt[0] = nxt[0] ^ din;
        return (nxt == 16'h0000) ? LFSR_SEED : nxt;
    endfunction

endpackage

// File: rtl/shout_sched_if.sv
// Control/status bundle between the entropy source, the scheduler and the
// per-emitter enable gating.
interface shout_sched_if #(
    parameter int N_CH       = 8,
    parameter int MAX_ACTIVE = 3
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int CNT_W = $clog2(MAX_ACTIVE + 1);

    logic [4:0]       rnd;
    logic             run;
    logic [N_CH-1:0]  mask;
    logic             force_all;
    logic [N_CH-1:0]  ch_en;
    logic [CNT_W-1:0] active_cnt;
    logic             grant;
    logic [CH_W-1:0]  grant_ch;

    modport master (
        output rnd, run, mask, force_all,
        input  ch_en, active_cnt, grant, grant_ch
    );

    modport slave (
        input  rnd, run, mask, force_all,
        output ch_en, active_cnt, grant, grant_ch
    );

endinterface

// File: rtl/shout_sched_slot.sv
// One scheduling slot: IDLE -> ON (dwell) -> GAP (quiet) -> IDLE, holding the
// owned channel id. Also exposes its next-cycle ON state so outputs can be registered.
module shout_slot
    import loud_box_pkg::*;
#(
    parameter int CH_W    = 3,
    parameter int DWELL_W = 12,
    parameter int GAP     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              freeze_i,
    input  logic              take_i,
    input  logic [CH_W-1:0]   ch_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic              stop_i,
    output slot_state_e       state_o,
    output logic [CH_W-1:0]   ch_o,
    output logic              on_nxt_o,
    output logic [CH_W-1:0]   ch_nxt_o
);

    slot_state_e        state_q;
    logic [DWELL_W-1:0] timer_q;
    logic [CH_W-1:0]    ch_q;
    logic               last_tick;

    assign last_tick = (timer_q == DWELL_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            ch_q    <= '0;
        end else if (!freeze_i) begin
            case (state_q)
                S_IDLE: begin
                    if (take_i) begin
                        state_q <= S_ON;
                        timer_q <= dwell_i;
                        ch_q    <= ch_i;
                    end
                end
                S_ON: begin
                    if (stop_i || last_tick) begin
                        state_q <= S_GAP;
                        timer_q <= DWELL_W'(GAP);
                    end else begin
                        timer_q <= timer_q - DWELL_W'(1);
                    end
                end
                S_GAP: begin
                    if (last_tick) begin
                        state_q <= S_IDLE;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q - DWELL_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    // Mirrors the transitions above so ch_en can change on the same edge as the state.
    always_comb begin
        on_nxt_o = 1'b0;
        ch_nxt_o = ch_q;
        if (freeze_i) begin
            on_nxt_o = (state_q == S_ON);
        end else begin
            case (state_q)
                S_IDLE: begin
                    on_nxt_o = take_i;
                    if (take_i) ch_nxt_o = ch_i;
                end
                S_ON:    on_nxt_o = !stop_i && !last_tick;
                default: on_nxt_o = 1'b0;
            endcase
        end
    end

    assign state_o = state_q;
    assign ch_o    = ch_q;

endmodule

// File: rtl/shout_sched.sv
// Noise-emitter time-slot scheduler: LFSR-driven channel picker feeding
// MAX_ACTIVE slot FSMs, with registered per-channel enables.
module shout_sched
    import loud_box_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int MAX_ACTIVE = 3,
    parameter int DWELL_W    = 12,
    parameter int MIN_DWELL  = 64,
    parameter int GAP        = 16,
    parameter int RAND_DWELL = 1
) (
    input logic          clk_in,
    input logic          reset,
    shout_sched_if.slave bus
);

    localparam int CH_W  = $clog2(N_CH);
    localparam int CNT_W = $clog2(MAX_ACTIVE + 1);

    logic                  rnd_s1_q, rnd_s2_q;
    logic [15:0]           lfsr_q;
    logic [N_CH-1:0]       ch_en_q, ch_en_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  grant_q, grant_d;
    logic [CH_W-1:0]       grant_ch_q;

    slot_state_e           slot_st     [MAX_ACTIVE];
    logic [CH_W-1:0]       slot_ch     [MAX_ACTIVE];
    logic [CH_W-1:0]       slot_ch_nxt [MAX_ACTIVE];
    logic [MAX_ACTIVE-1:0] slot_take, slot_stop, slot_on_nxt;

    logic [N_CH-1:0]       owned;
    logic [CH_W-1:0]       pick_ch, cand;
    logic                  pick_found, grant_ok;
    logic [DWELL_W-1:0]    dwell;
    logic                  unused_rnd;

    // Only rnd[0] feeds the LFSR; the remaining entropy bits are not needed here.
    assign unused_rnd = ^bus.rnd[4:1];

    assign dwell = (RAND_DWELL != 0)
                 ? DWELL_W'(MIN_DWELL) + {1'b0, lfsr_q[DWELL_W-2:0]}
                 : DWELL_W'(MIN_DWELL);

    for (genvar s = 0; s < MAX_ACTIVE; s++) begin : g_slot
        shout_slot #(
            .CH_W    (CH_W),
            .DWELL_W (DWELL_W),
            .GAP     (GAP)
        ) u_slot (
            .clk_i    (clk_in),
            .rst_i    (reset),
            .freeze_i (bus.force_all),
            .take_i   (slot_take[s]),
            .ch_i     (pick_ch),
            .dwell_i  (dwell),
            .stop_i   (slot_stop[s]),
            .state_o  (slot_st[s]),
            .ch_o     (slot_ch[s]),
            .on_nxt_o (slot_on_nxt[s]),
            .ch_nxt_o (slot_ch_nxt[s])
        );
    end

    // A channel stays owned through GAP so it cannot be re-granted while quiet.
    always_comb begin
        owned     = '0;
        slot_stop = '0;
        for (int s = 0; s < MAX_ACTIVE; s++) begin
            if (slot_st[s] != S_IDLE) owned[slot_ch[s]] = 1'b1;
            slot_stop[s] = !bus.run || !bus.mask[slot_ch[s]];
        end
    end

    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        cand       = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = lfsr_q[CH_W-1:0] + CH_W'(k);
            if (!pick_found && bus.mask[cand] && !owned[cand]) begin
                pick_found = 1'b1;
                pick_ch    = cand;
            end
        end
    end

    assign grant_ok = bus.run && !bus.force_all && pick_found;

    always_comb begin
        slot_take = '0;
        grant_d   = 1'b0;
        for (int s = 0; s < MAX_ACTIVE; s++) begin
            if (!grant_d && grant_ok && slot_st[s] == S_IDLE) begin
                slot_take[s] = 1'b1;
                grant_d      = 1'b1;
            end
        end
    end

    always_comb begin
        ch_en_d = '0;
        cnt_d   = '0;
        for (int s = 0; s < MAX_ACTIVE; s++) begin
            if (slot_on_nxt[s]) begin
                ch_en_d[slot_ch_nxt[s]] = 1'b1;
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
        if (bus.force_all) ch_en_d = bus.mask;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            rnd_s1_q   <= 1'b0;
            rnd_s2_q   <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            ch_en_q    <= '0;
            cnt_q      <= '0;
            grant_q    <= 1'b0;
            grant_ch_q <= '0;
        end else begin
            rnd_s1_q <= bus.rnd[0];
            rnd_s2_q <= rnd_s1_q;
            lfsr_q   <= lfsr_next(lfsr_q, rnd_s2_q);
            ch_en_q  <= ch_en_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            if (grant_d) grant_ch_q <= pick_ch;
        end
    end

    assign bus.ch_en      = ch_en_q;
    assign bus.active_cnt = cnt_q;
    assign bus.grant      = grant_q;
    assign bus.grant_ch   = grant_ch_q;

endmodule
